// File: rtl/fountain_enc_sched_if.sv
// fountain_enc_sched_if: block control, source-word and encoded-symbol signals of the fountain encoder.
interface fountain_enc_sched_if #(parameter int K = 8, parameter int W = 64);
  logic start;
  logic [15:0] seed;
  logic [7:0] num_sym;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [K-1:0] out_mask;
  logic busy;
  logic done;
  modport master (
    output start, seed, num_sym, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_mask, busy, done
  );
  modport slave (
    input start, seed, num_sym, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mask, busy, done
  );
endinterface

// File: rtl/fountain_enc_sched.sv
// fountain_enc_sched: loads K source words, then emits LFSR-masked XOR symbols one at a time.
module fountain_enc_sched #(
  parameter int K = 8,
  parameter int W = 64
) (
  input logic clk,
  input logic rst_n,
  fountain_enc_sched_if.slave bus
);
  localparam int CW = $clog2(K);
  typedef enum logic [2:0] {IDLE, LOAD, GEN, XOR, OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [K-1:0] mask_q, mask_d;
  logic [W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] sym_q, sym_d, num_q, num_d, sym_inc;
  logic [W-1:0] buf_q [K];
  logic [W-1:0] buf_d [K];
  assign lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign sym_inc = sym_q + 8'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q <= '0;
      mask_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      sym_q <= '0;
      num_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      mask_q <= mask_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sym_q <= sym_d;
      num_q <= num_d;
    end
  end
  // Source buffer is deliberately unreset; it is always fully rewritten before use.
  always_ff @(posedge clk) buf_q <= buf_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.num_sym == 8'd0) ? DONE : LOAD;
      LOAD: if (bus.in_valid && cnt_q == CW'(K - 1)) state_d = GEN;
      GEN: state_d = XOR;
      XOR: if (cnt_q == CW'(K - 1)) state_d = OUT;
      OUT: if (bus.out_ready) state_d = (sym_inc == num_q) ? DONE : GEN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    lfsr_d = lfsr_q;
    mask_d = mask_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sym_d = sym_q;
    num_d = num_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        lfsr_d = (bus.seed == 16'd0) ? 16'hACE1 : bus.seed;
        num_d = bus.num_sym;
        cnt_d = '0;
        sym_d = '0;
      end
      LOAD: if (bus.in_valid) begin
        buf_d[cnt_q] = bus.in_data;
        cnt_d = cnt_q + 1'b1;
      end
      GEN: begin
        lfsr_d = lfsr_nx;
        mask_d = (lfsr_nx[K-1:0] == '0) ? K'(1) : lfsr_nx[K-1:0];
        acc_d = '0;
        cnt_d = '0;
      end
      XOR: begin
        acc_d = acc_q ^ (mask_q[cnt_q] ? buf_q[cnt_q] : '0);
        cnt_d = cnt_q + 1'b1;
      end
      OUT: if (bus.out_ready) sym_d = sym_inc;
      default: ;
    endcase
  end
  always_comb begin
    bus.in_ready = state_q == LOAD;
    bus.out_valid = state_q == OUT;
    bus.out_data = (state_q == OUT) ? acc_q : '0;
    bus.out_mask = (state_q == OUT) ? mask_q : '0;
    bus.busy = state_q != IDLE;
    bus.done = state_q == DONE;
  end
endmodule

// File: tb/tb_fountain_enc_sched.sv
// tb_fountain_enc_sched: directed and randomized blocks checked against a symbol-level reference model.
module tb_fountain_enc_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [63:0] words [8];
  logic [7:0] em [256];
  logic [63:0] ed [256];
  logic [15:0] sd;
  int n;
  always #5 clk = ~clk;
  fountain_enc_sched_if #(.K(8), .W(64)) bus ();
  fountain_enc_sched #(.K(8), .W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Symbol k of a block: advance the LFSR k+1 times from the seed, take its low byte as mask.
  task automatic model(input logic [15:0] seed, input int cnt);
    logic [15:0] s;
    logic [7:0] m;
    logic [63:0] a;
    s = (seed == 16'd0) ? 16'hACE1 : seed;
    for (int k = 0; k < cnt; k++) begin
      s = ((s << 1) | 16'(((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 16'd1));
      m = (s[7:0] == 8'd0) ? 8'h01 : s[7:0];
      a = '0;
      for (int i = 0; i < 8; i++) if (m[i]) a ^= words[i];
      em[k] = m;
      ed[k] = a;
    end
  endtask

  task automatic rand_words;
    for (int i = 0; i < 8; i++) words[i] = {$urandom, $urandom};
  endtask

  task automatic start_blk(input logic [15:0] seed, input logic [7:0] cnt);
    bus.start = 1'b1;
    bus.seed = seed;
    bus.num_sym = cnt;
    tick;
    bus.start = 1'b0;
    bus.seed = 16'($urandom);
    bus.num_sym = 8'($urandom);
  endtask

  task automatic load(input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit rdy_ok = 1'b1;
    while (idx < 8 && cyc < 200) begin
      bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data = bus.in_valid ? words[idx] : {$urandom, $urandom};
      bus.start = rnd && ($urandom_range(0, 3) == 0);
      rdy_ok &= (bus.in_ready === 1'b1);
      tick;
      if (bus.in_valid) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    chk("load_count", 64'(idx), 64'd8);
    chk("in_ready_load", 64'(rdy_ok), 64'd1);
  endtask

  task automatic get_sym(input int k, input int hold, input bit keep_rdy);
    int cyc = 0;
    bit zero_ok = 1'b1;
    bit st_ok = 1'b1;
    while (!bus.out_valid && cyc < 40) begin
      zero_ok &= (bus.out_data === 64'd0 && bus.out_mask === 8'd0 && bus.in_ready === 1'b0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.seed = 16'($urandom);
      bus.num_sym = 8'($urandom);
      tick;
      cyc++;
    end
    bus.start = 1'b0;
    chk($sformatf("latency_sym%0d", k), 64'(cyc), 64'd9);
    chk($sformatf("zero_when_invalid_sym%0d", k), 64'(zero_ok), 64'd1);
    chk($sformatf("mask_sym%0d", k), 64'(bus.out_mask), 64'(em[k]));
    chk($sformatf("data_sym%0d", k), bus.out_data, ed[k]);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        tick;
        st_ok &= (bus.out_valid === 1'b1 && bus.out_data === ed[k] && bus.out_mask === em[k]);
      end
      chk($sformatf("hold_stable_sym%0d", k), 64'(st_ok), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = keep_rdy;
  endtask

  task automatic finish_blk;
    chk("done_pulse", 64'({bus.done, bus.busy, bus.out_valid}), 64'b110);
    tick;
    chk("done_clear", 64'({bus.done, bus.busy}), 64'd0);
    tick;
    chk("done_once", 64'({bus.done, bus.busy}), 64'd0);
  endtask

  task automatic run_blk(input logic [15:0] seed, input int cnt, input bit rnd);
    model(seed, cnt);
    start_blk(seed, 8'(cnt));
    load(rnd);
    for (int k = 0; k < cnt; k++)
      get_sym(k, rnd ? $urandom_range(0, 3) : 0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    bus.out_ready = 1'b0;
    finish_blk;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.seed = '0;
    bus.num_sym = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_flags", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.done}), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_mask", 64'(bus.out_mask), 64'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_after_rst", 64'(bus.busy), 64'd0);
    // Reference block: seed 1, words i+1, ready held high throughout.
    for (int i = 0; i < 8; i++) words[i] = 64'(i + 1);
    model(16'h0001, 2);
    chk("ref_mask0", 64'(em[0]), 64'h02);
    chk("ref_data0", ed[0], 64'd2);
    chk("ref_mask1", 64'(em[1]), 64'h04);
    chk("ref_data1", ed[1], 64'd3);
    run_blk(16'h0001, 2, 1'b0);
    // Zero seed falls back to 16'hACE1.
    rand_words;
    model(16'h0000, 1);
    chk("seed0_mask", 64'(em[0]), 64'hC3);
    chk("seed0_data", ed[0], words[0] ^ words[1] ^ words[6] ^ words[7]);
    run_blk(16'h0000, 1, 1'b0);
    // Empty block goes straight to DONE.
    start_blk(16'h1234, 8'd0);
    chk("empty_done", 64'({bus.done, bus.in_ready, bus.out_valid}), 64'b100);
    tick;
    chk("empty_idle", 64'({bus.done, bus.busy, bus.in_ready, bus.out_valid}), 64'd0);
    // Backpressure: first symbol stalled 20 cycles.
    rand_words;
    sd = 16'($urandom);
    model(sd, 3);
    start_blk(sd, 8'd3);
    load(1'b1);
    get_sym(0, 20, 1'b0);
    get_sym(1, 0, 1'b0);
    get_sym(2, 2, 1'b1);
    bus.out_ready = 1'b0;
    finish_blk;
    // Reset in the middle of symbol 1's accumulation, then replay the block.
    rand_words;
    sd = 16'($urandom);
    model(sd, 3);
    start_blk(sd, 8'd3);
    load(1'b0);
    get_sym(0, 0, 1'b0);
    for (int i = 0; i < 4; i++) tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.done}), 64'd0);
    chk("midrst_data", bus.out_data | 64'(bus.out_mask), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("midrst_idle", 64'(bus.busy), 64'd0);
    run_blk(sd, 1, 1'b0);
    // Randomized blocks with random valid/ready gaps and stray start pulses.
    for (int b = 0; b < 6; b++) begin
      rand_words;
      sd = (b == 0) ? 16'h0000 : 16'($urandom);
      n = $urandom_range(1, 5);
      run_blk(sd, n, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
